// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: central stall/flush scheduler for the 5-stage core (F,D,E,M,W).
// Arbitrates decode load-use, execute divider and AXI ibus/dbus waits, and
// sequences exception/ERET redirects so they wait for any in-flight fetch.
//
// Ports:
//   clk, rst                 core clock (rising edge), async active-low reset
//   stall_reqD_load          load-use hazard from decode
//   stall_reqE_div           divider busy in execute
//   ibus_busy, dbus_busy     instruction / data AXI transaction outstanding
//   exc_valid, exc_pc        exception/ERET commit from CP0 and its target PC
//   stallF..stallW           hold the pipeline register of that stage (combinational)
//   flushD..flushW           clear the pipeline register of that stage (combinational)
//   redirect_valid/_pc       registered one-cycle redirect strobe and target
//   stall_cnt                wrapping count of cycles with stallF=1
module pipeline_ctrl #(
    parameter int unsigned PC_W  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_reqD_load,
    input  logic             stall_reqE_div,
    input  logic             ibus_busy,
    input  logic             dbus_busy,
    input  logic             exc_valid,
    input  logic [PC_W-1:0]  exc_pc,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             stallW,
    output logic             flushD,
    output logic             flushE,
    output logic             flushM,
    output logic             flushW,
    output logic             redirect_valid,
    output logic [PC_W-1:0]  redirect_pc,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        EXC_WAIT = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [PC_W-1:0]   pc_latch_q;
    logic [PC_W-1:0]   pc_latch_d;

    // Next-state and stall/flush decode; only the highest-priority request applies.
    always_comb begin
        state_d    = state_q;
        pc_latch_d = pc_latch_q;
        stallF = 1'b0; stallD = 1'b0; stallE = 1'b0; stallM = 1'b0; stallW = 1'b0;
        flushD = 1'b0; flushE = 1'b0; flushM = 1'b0; flushW = 1'b0;

        case (state_q)
            RUN: begin
                if (exc_valid && !dbus_busy) begin
                    flushD     = 1'b1;
                    flushE     = 1'b1;
                    flushM     = 1'b1;
                    pc_latch_d = exc_pc;
                    state_d    = ibus_busy ? EXC_WAIT : REDIRECT;
                end else if (dbus_busy) begin
                    // Exception stays deferred until the data transaction drains.
                    stallF = 1'b1; stallD = 1'b1; stallE = 1'b1; stallM = 1'b1;
                    flushW = 1'b1;
                end else if (stall_reqE_div) begin
                    stallF = 1'b1; stallD = 1'b1; stallE = 1'b1;
                    flushM = 1'b1;
                end else if (stall_reqD_load) begin
                    stallF = 1'b1; stallD = 1'b1;
                    flushE = 1'b1;
                end else if (ibus_busy) begin
                    stallF = 1'b1;
                    flushD = 1'b1;
                end
            end
            EXC_WAIT: begin
                // The fetch still in flight is discarded through flushD.
                stallF = 1'b1;
                flushD = 1'b1;
                if (!ibus_busy) begin
                    state_d = REDIRECT;
                end
            end
            REDIRECT: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        // Inputs may be active while reset is held; keep the pipeline controls quiet.
        if (!rst) begin
            stallF = 1'b0; stallD = 1'b0; stallE = 1'b0; stallM = 1'b0; stallW = 1'b0;
            flushD = 1'b0; flushE = 1'b0; flushM = 1'b0; flushW = 1'b0;
        end
    end

    // State, latched target, registered redirect and stall counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= RUN;
            pc_latch_q     <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            stall_cnt      <= '0;
        end else begin
            state_q        <= state_d;
            pc_latch_q     <= pc_latch_d;
            redirect_valid <= (state_d == REDIRECT);
            if (state_d == REDIRECT) begin
                redirect_pc <= pc_latch_d;
            end
            stall_cnt      <= stall_cnt + CNT_W'(stallF);
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Testbench for pipeline_ctrl: directed scenarios plus randomized traffic,
// all checked against a behavioural model of the stall/redirect rules.
module tb_pipeline_ctrl;

    localparam int unsigned PC_W  = 32;
    localparam int unsigned CNT_W = 8;

    typedef struct packed {
        logic [8:0]       ctl;   // {stallF,D,E,M,W, flushD,E,M,W}
        logic             rv;
        logic [PC_W-1:0]  pc;
        logic [CNT_W-1:0] cnt;
    } snap_t;

    logic             clk;
    logic             rst;
    logic             ld, dv, ib, db, ex;
    logic [PC_W-1:0]  epc;
    logic             stallF, stallD, stallE, stallM, stallW;
    logic             flushD, flushE, flushM, flushW;
    logic             redirect_valid;
    logic [PC_W-1:0]  redirect_pc;
    logic [CNT_W-1:0] stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    bit              m_wait;
    bit              m_redir;
    logic [PC_W-1:0] m_latch;
    logic [PC_W-1:0] m_rpc;
    int              m_cnt;

    pipeline_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .stall_reqD_load(ld), .stall_reqE_div(dv),
        .ibus_busy(ib), .dbus_busy(db),
        .exc_valid(ex), .exc_pc(epc),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM), .stallW(stallW),
        .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_wait  = 1'b0;
        m_redir = 1'b0;
        m_latch = '0;
        m_rpc   = '0;
        m_cnt   = 0;
    endtask

    // One clock: drive inputs, sample controls before the edge and registers after it.
    task automatic cycle(input logic i_ld, input logic i_dv, input logic i_ib,
                         input logic i_db, input logic i_ex, input logic [PC_W-1:0] i_pc,
                         output snap_t got, output snap_t exp);
        @(negedge clk);
        ld = i_ld; dv = i_dv; ib = i_ib; db = i_db; ex = i_ex; epc = i_pc;
        #1;
        got.ctl = {stallF, stallD, stallE, stallM, stallW, flushD, flushE, flushM, flushW};
        exp.ctl = 9'b0;
        if (m_redir)                exp.ctl = 9'b00000_0000;
        else if (m_wait)            exp.ctl = 9'b10000_1000;
        else if (i_ex && !i_db)     exp.ctl = 9'b00000_1110;
        else if (i_db)              exp.ctl = 9'b11110_0001;
        else if (i_dv)              exp.ctl = 9'b11100_0010;
        else if (i_ld)              exp.ctl = 9'b11000_0100;
        else if (i_ib)              exp.ctl = 9'b10000_1000;
        m_cnt = (m_cnt + int'(exp.ctl[8])) % (1 << CNT_W);
        if (m_redir) begin
            m_redir = 1'b0;
        end else if (m_wait) begin
            if (!i_ib) begin
                m_wait  = 1'b0;
                m_redir = 1'b1;
                m_rpc   = m_latch;
            end
        end else if (i_ex && !i_db) begin
            m_latch = i_pc;
            if (i_ib) m_wait = 1'b1;
            else begin
                m_redir = 1'b1;
                m_rpc   = i_pc;
            end
        end
        exp.rv  = m_redir;
        exp.pc  = m_rpc;
        exp.cnt = CNT_W'(m_cnt);
        @(posedge clk);
        #1;
        got.rv  = redirect_valid;
        got.pc  = redirect_pc;
        got.cnt = stall_cnt;
    endtask

    task automatic test_reset();
        snap_t got;
        rst = 1'b0;
        ld = 1'b1; dv = 1'b1; ib = 1'b1; db = 1'b1; ex = 1'b1; epc = 32'h1234_5678;
        #12;
        got.ctl = {stallF, stallD, stallE, stallM, stallW, flushD, flushE, flushM, flushW};
        got.rv = redirect_valid; got.pc = redirect_pc; got.cnt = stall_cnt;
        n_checks++;
        if (got !== '0) begin
            n_errors++;
            $display("FAIL reset_state: got=%h expected=0", got);
        end
        model_reset();
        @(negedge clk);
        ld = 1'b0; dv = 1'b0; ib = 1'b0; db = 1'b0; ex = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_load_use();
        snap_t got, exp;
        cycle(1, 0, 0, 0, 0, '0, got, exp);
        n_checks++;
        if (got !== exp || got.ctl !== 9'b11000_0100 || got.cnt !== 8'd1) begin
            n_errors++;
            $display("FAIL load_use: got=%h expected=%h", got, exp);
        end
        cycle(0, 0, 0, 0, 0, '0, got, exp);
        n_checks++;
        if (got !== exp || got.ctl !== 9'b0) begin
            n_errors++;
            $display("FAIL load_use_idle: got=%h expected=%h", got, exp);
        end
    endtask

    task automatic test_div_priority();
        snap_t got, exp;
        int    start;
        start = m_cnt;
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, 0, 0, 0, '0, got, exp);
            n_checks++;
            if (got !== exp || got.ctl !== 9'b11100_0010) begin
                n_errors++;
                $display("FAIL div_over_load[%0d]: got=%h expected=%h", i, got, exp);
            end
        end
        n_checks++;
        if (int'(got.cnt) != start + 3) begin
            n_errors++;
            $display("FAIL div_stall_cnt: got=%0d expected=%0d", got.cnt, start + 3);
        end
    endtask

    task automatic test_exc_idle();
        snap_t got, exp;
        cycle(0, 0, 0, 0, 1, 32'hBFC0_0380, got, exp);
        n_checks++;
        if (got !== exp || got.ctl !== 9'b00000_1110 || got.rv !== 1'b1 || got.pc !== 32'hBFC0_0380) begin
            n_errors++;
            $display("FAIL exc_idle_accept: got=%h expected=%h", got, exp);
        end
        cycle(1, 0, 0, 0, 1, 32'h0000_0111, got, exp);
        n_checks++;
        if (got !== exp || got.ctl !== 9'b0 || got.rv !== 1'b0 || got.pc !== 32'hBFC0_0380) begin
            n_errors++;
            $display("FAIL exc_idle_redirect: got=%h expected=%h", got, exp);
        end
    endtask

    task automatic test_exc_ibus_wait();
        snap_t got, exp;
        cycle(0, 0, 1, 0, 1, 32'h8000_0180, got, exp);
        n_checks++;
        if (got !== exp || got.ctl !== 9'b00000_1110 || got.rv !== 1'b0) begin
            n_errors++;
            $display("FAIL exc_wait_accept: got=%h expected=%h", got, exp);
        end
        for (int i = 1; i <= 4; i++) begin
            cycle(1, 1, (i < 4), 0, 1, 32'hDEAD_0000, got, exp);
            n_checks++;
            if (got !== exp || got.ctl !== 9'b10000_1000 || got.rv !== (i == 4)) begin
                n_errors++;
                $display("FAIL exc_wait_T%0d: got=%h expected=%h", i, got, exp);
            end
        end
        n_checks++;
        if (got.pc !== 32'h8000_0180) begin
            n_errors++;
            $display("FAIL exc_wait_pc: got=%h expected=80000180", got.pc);
        end
        cycle(0, 0, 0, 0, 0, '0, got, exp);
        n_checks++;
        if (got !== exp || got.ctl !== 9'b0 || got.rv !== 1'b0) begin
            n_errors++;
            $display("FAIL exc_wait_redirect: got=%h expected=%h", got, exp);
        end
    endtask

    task automatic test_exc_dbus();
        snap_t got, exp;
        for (int i = 1; i <= 2; i++) begin
            cycle(0, 0, 0, 1, 1, 32'h9FC0_0000, got, exp);
            n_checks++;
            if (got !== exp || got.ctl !== 9'b11110_0001 || got.rv !== 1'b0) begin
                n_errors++;
                $display("FAIL exc_dbus_defer[%0d]: got=%h expected=%h", i, got, exp);
            end
        end
        cycle(0, 0, 0, 0, 1, 32'h9FC0_0000, got, exp);
        n_checks++;
        if (got !== exp || got.ctl !== 9'b00000_1110 || got.rv !== 1'b1 || got.pc !== 32'h9FC0_0000) begin
            n_errors++;
            $display("FAIL exc_dbus_accept: got=%h expected=%h", got, exp);
        end
        cycle(0, 0, 0, 0, 0, '0, got, exp);
    endtask

    task automatic test_cnt_wrap();
        snap_t got, exp;
        for (int i = 0; i < 600 && m_cnt != 255; i++) begin
            cycle(0, 0, 1, 0, 0, '0, got, exp);
        end
        n_checks++;
        if (m_cnt != 255 || stall_cnt !== 8'hFF) begin
            n_errors++;
            $display("FAIL cnt_reach_max: got=%h expected=ff", stall_cnt);
        end
        cycle(1, 0, 0, 0, 0, '0, got, exp);
        n_checks++;
        if (got !== exp || got.cnt !== 8'h00) begin
            n_errors++;
            $display("FAIL cnt_wrap: got=%h expected=%h", got, exp);
        end
    endtask

    task automatic test_reset_mid_wait();
        snap_t got, exp;
        cycle(0, 0, 1, 0, 1, 32'hA5A5_0004, got, exp);
        cycle(0, 0, 1, 0, 0, '0, got, exp);
        @(negedge clk);
        ld = 1'b1; dv = 1'b1; ib = 1'b1; db = 1'b1; ex = 1'b1;
        rst = 1'b0;
        #1;
        got.ctl = {stallF, stallD, stallE, stallM, stallW, flushD, flushE, flushM, flushW};
        got.rv = redirect_valid; got.pc = redirect_pc; got.cnt = stall_cnt;
        n_checks++;
        if (got !== '0) begin
            n_errors++;
            $display("FAIL reset_mid_wait: got=%h expected=0", got);
        end
        model_reset();
        @(posedge clk);
        #1;
        ld = 1'b0; dv = 1'b0; ib = 1'b0; db = 1'b0; ex = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle(0, 0, 0, 0, 0, '0, got, exp);
            n_checks++;
            if (got !== exp || got.rv !== 1'b0 || got.ctl !== 9'b0) begin
                n_errors++;
                $display("FAIL reset_drop_redirect[%0d]: got=%h expected=%h", i, got, exp);
            end
        end
    endtask

    task automatic test_random();
        snap_t got, exp;
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 5) == 0), $urandom(), got, exp);
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL random[%0d]: got=%h expected=%h", i, got, exp);
            end
        end
    endtask

    initial begin
        clk = 1'b0;
        model_reset();
        test_reset();
        test_load_use();
        test_div_priority();
        test_exc_idle();
        test_exc_ibus_wait();
        test_exc_dbus();
        test_cnt_wrap();
        test_reset_mid_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
